writeback_commit_queue: RTL

//  Receiving end of the execution-stage writeback bundle. Accepts 0-2 register writes
//  per cycle (reg1 and reg2 slots) from the writeback mux. Queues them in order and

---
 rtl/writeback_commit_queue_pkg.sv | 19 +
 rtl/writeback_commit_queue_if.sv | 48 ++++
 rtl/writeback_commit_queue_wb_fifo_2in1out.sv | 61 ++++++
 rtl/writeback_commit_queue.sv | 123 ++++++++++++
 4 files changed

// File: rtl/writeback_commit_queue_pkg.sv
// Shared definitions for the writeback commit queue.
//   ADDR_W / DATA_W / UNIT_W : register address, data and unit-code widths
//   FX_UNIT_CODE             : default unit code whose reg2 slot carries CR/XER bits
//   wb_entry_t               : one queued register-file write {is_cond, addr, val}
package writeback_commit_queue_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned UNIT_W = 2;

  localparam logic [UNIT_W-1:0] FX_UNIT_CODE = 2'd0;

  typedef struct packed {
    logic              is_cond;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } wb_entry_t;

endpackage

// File: rtl/writeback_commit_queue_if.sv
// Writeback bundle from execution plus the register-file write port and stall.
//   master : execution/testbench side (drives the bundle, receives the write port)
//   slave  : the commit queue
// Forwarding lookup signals exist only when WB_FORWARD_EN is defined.
interface writeback_commit_queue_if;
  import writeback_commit_queue_pkg::*;

  logic [UNIT_W-1:0] functionalUnitCode_i;
  logic              reg1WritebackEnable_i;
  logic              reg2WritebackEnable_i;
  logic [ADDR_W-1:0] reg1WritebackAddress_i;
  logic [ADDR_W-1:0] reg2WritebackAddress_i;
  logic [DATA_W-1:0] reg1WritebackVal_i;
  logic [DATA_W-1:0] reg2WritebackVal_i;
  logic              stall_o;
  logic              wrEnable_o;
  logic              wrIsCond_o;
  logic [ADDR_W-1:0] wrAddress_o;
  logic [DATA_W-1:0] wrValue_o;
  logic              overflow_o;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0] fwdAddress_i;
  logic              fwdHit_o;
  logic [DATA_W-1:0] fwdValue_o;
`endif

  modport master (
    output functionalUnitCode_i, reg1WritebackEnable_i, reg2WritebackEnable_i,
    output reg1WritebackAddress_i, reg2WritebackAddress_i,
    output reg1WritebackVal_i, reg2WritebackVal_i,
    input  stall_o, wrEnable_o, wrIsCond_o, wrAddress_o, wrValue_o, overflow_o
`ifdef WB_FORWARD_EN
    , output fwdAddress_i
    , input  fwdHit_o, fwdValue_o
`endif
  );

  modport slave (
    input  functionalUnitCode_i, reg1WritebackEnable_i, reg2WritebackEnable_i,
    input  reg1WritebackAddress_i, reg2WritebackAddress_i,
    input  reg1WritebackVal_i, reg2WritebackVal_i,
    output stall_o, wrEnable_o, wrIsCond_o, wrAddress_o, wrValue_o, overflow_o
`ifdef WB_FORWARD_EN
    , input  fwdAddress_i
    , output fwdHit_o, fwdValue_o
`endif
  );
endinterface

// File: rtl/writeback_commit_queue_wb_fifo_2in1out.sv
// wb_fifo_2in1out: circular buffer taking up to two entries and releasing one per cycle.
//   clk, rst     : clock, synchronous active-high reset (pointers/count only)
//   push0/din0   : first entry this cycle
//   push1/din1   : second entry, stored behind din0 (only used together with push0)
//   pop / head   : release the oldest entry / oldest entry
//   count        : number of stored entries
//   entries, rd_ptr : raw storage view for forwarding (WB_FORWARD_EN only)
module wb_fifo_2in1out
  import writeback_commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic             push1,
  input  wb_entry_t        din0,
  input  wb_entry_t        din1,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
`ifdef WB_FORWARD_EN
  , output wb_entry_t        entries [DEPTH]
  , output logic [PTR_W-1:0] rd_ptr
`endif
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_q;

  // Power-of-two depth: pointer arithmetic wraps naturally.
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign head      = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]    <= din0;
    if (push1) mem[wr_ptr_p1] <= din1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count    <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

`ifdef WB_FORWARD_EN
  assign entries = mem;
  assign rd_ptr  = rd_ptr_q;
`endif

endmodule

// File: rtl/writeback_commit_queue.sv
// writeback_commit_queue: queues 0-2 register writes per cycle from the writeback
// bundle and drains them in order, one per cycle, to the register-file write port.
//   clock_i, reset_i : clock, synchronous active-high reset
//   wb (slave)       : writeback bundle in; wr* write port, stall_o, sticky overflow_o out
// Optional: define WB_FORWARD_EN to add the fwd* lookup (youngest pending GPR write).
module writeback_commit_queue
  import writeback_commit_queue_pkg::*;
#(
  parameter int unsigned       DEPTH        = 8,
  parameter int unsigned       STALL_MARGIN = 4,
  parameter logic [UNIT_W-1:0] FXUnitCode   = FX_UNIT_CODE
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  writeback_commit_queue_if.slave wb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] n_req;
  logic             deq;
  logic             en1, en2;
  logic             push0, push1, drop;
  wb_entry_t        e1, e2, din0, head;

  logic              wr_en_q, wr_cond_q, ovf_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_val_q;

`ifdef WB_FORWARD_EN
  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
`endif

  assign en1 = wb.reg1WritebackEnable_i;
  assign en2 = wb.reg2WritebackEnable_i;

  always_comb begin
    e1 = '{is_cond: 1'b0, addr: wb.reg1WritebackAddress_i, val: wb.reg1WritebackVal_i};
    e2 = '{is_cond: (wb.functionalUnitCode_i == FXUnitCode),
           addr: wb.reg2WritebackAddress_i, val: wb.reg2WritebackVal_i};
  end

  // Space includes the slot freed by this cycle's dequeue, so full + deq + 1 enq fits.
  assign deq   = (count != '0);
  assign space = CNT_W'(DEPTH) - count + CNT_W'(deq);
  assign n_req = CNT_W'(en1) + CNT_W'(en2);

  // Entries are compacted in slot order: slot1 (if valid) always goes first.
  assign din0  = en1 ? e1 : e2;
  assign push0 = (en1 | en2) && (space != '0);
  assign push1 = en1 && en2 && (space >= CNT_W'(2));
  assign drop  = (n_req > space);

  wb_fifo_2in1out #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock_i),
    .rst     (reset_i),
    .push0   (push0),
    .push1   (push1),
    .din0    (din0),
    .din1    (e2),
    .pop     (deq),
    .head    (head),
    .count   (count)
`ifdef WB_FORWARD_EN
    , .entries (entries)
    , .rd_ptr  (rd_ptr)
`endif
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_en_q   <= 1'b0;
      wr_cond_q <= 1'b0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_en_q <= deq;
      if (deq) begin
        wr_cond_q <= head.is_cond;
        wr_addr_q <= head.addr;
        wr_val_q  <= head.val;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign wb.wrEnable_o = wr_en_q;
  assign wb.wrIsCond_o = wr_cond_q;
  assign wb.wrAddress_o = wr_addr_q;
  assign wb.wrValue_o  = wr_val_q;
  assign wb.overflow_o = ovf_q;
  assign wb.stall_o    = (CNT_W'(DEPTH) - count) < CNT_W'(STALL_MARGIN);

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so later matches win; the entry on wr* is older than all queued ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    wb.fwdHit_o   = 1'b0;
    wb.fwdValue_o = '0;
    idx           = '0;
    if (wr_en_q && !wr_cond_q && (wr_addr_q == wb.fwdAddress_i)) begin
      wb.fwdHit_o   = 1'b1;
      wb.fwdValue_o = wr_val_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && !entries[idx].is_cond &&
          (entries[idx].addr == wb.fwdAddress_i)) begin
        wb.fwdHit_o   = 1'b1;
        wb.fwdValue_o = entries[idx].val;
      end
    end
  end
`endif

endmodule
